// File: rtl/beepboop_pkg.sv
// beepboop_pkg: identifier ROM and serializer state type shared across the beepboop top level
package beepboop_pkg;
  localparam int ID_LEN = 8;
  localparam logic [7:0] ID_ROM [ID_LEN] = '{8'h62, 8'h65, 8'h65, 8'h70, 8'h62, 8'h6f, 8'h6f, 8'h70};
  typedef enum logic [1:0] {GAP, DATA, TERM} id_state_t;
  function automatic logic rom_nonzero();
    for (int i = 0; i < ID_LEN; i++)
      if (ID_ROM[i] == 8'h00) return 1'b0;
    return 1'b1;
  endfunction
endpackage

// File: rtl/beepboop_id_serializer.sv
// beepboop_id_serializer: repeats ID_ROM MSB-first with a NUL terminator and an idle gap before each frame
module beepboop_id_serializer
  import beepboop_pkg::*;
#(
  parameter int GAP_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic id_valid,
  output logic id_bit
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int CW = $clog2(ID_LEN + 1);
  localparam int AW = (ID_LEN > 1) ? $clog2(ID_LEN) : 1;
  if (GAP_CYCLES < 1 || !rom_nonzero()) begin : g_bad_cfg
    $error("beepboop_id_serializer: GAP_CYCLES must be >= 1 and every ID_ROM byte non-zero");
  end
  id_state_t     state;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] char_idx;
  logic [CW-1:0] char_nxt;
  logic [2:0]    bit_idx;
  logic [7:0]    cur_chr;
  logic [7:0]    nxt_chr;
  // ROM lookup for the character on the wire and the one that follows it
  always_comb begin
    char_nxt = char_idx + CW'(1);
    cur_chr  = ID_ROM[char_idx[AW-1:0]];
    nxt_chr  = ID_ROM[char_nxt[AW-1:0]];
  end
  // Gap counting, bit/char sequencing and registered outputs; bit_idx doubles as the terminator counter
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= GAP;
      gap_cnt  <= '0;
      char_idx <= '0;
      bit_idx  <= 3'd7;
      id_valid <= 1'b0;
      id_bit   <= 1'b0;
    end else
      case (state)
        GAP:
          if (en) begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
              gap_cnt  <= '0;
              state    <= DATA;
              char_idx <= '0;
              bit_idx  <= 3'd7;
              id_valid <= 1'b1;
              id_bit   <= ID_ROM[0][7];
            end else
              gap_cnt <= gap_cnt + GW'(1);
          end
        DATA: begin
          bit_idx <= bit_idx - 3'd1;
          if (bit_idx != 3'd0)
            id_bit <= cur_chr[bit_idx - 3'd1];
          else if (char_idx == CW'(ID_LEN - 1)) begin
            state  <= TERM;
            id_bit <= 1'b0;
          end else begin
            char_idx <= char_nxt;
            id_bit   <= nxt_chr[7];
          end
        end
        TERM: begin
          bit_idx <= bit_idx - 3'd1;
          if (bit_idx == 3'd0) begin
            state    <= GAP;
            char_idx <= '0;
            id_valid <= 1'b0;
          end
        end
        default: state <= GAP;
      endcase
endmodule

// File: tb/tb_beepboop_id_serializer.sv
// tb_beepboop_id_serializer: table vectors, hand sequences and a randomized run against a frame-position model
module tb_beepboop_id_serializer;
  localparam int G  = 16;
  localparam int FL = 72;
  localparam logic [71:0] EXP_FRAME = {"beepboop", 8'h00};
  typedef struct packed {
    logic en;
    logic vld;
    logic dat;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en    = 1'b0;
  logic id_valid;
  logic id_bit;
  int   pass_cnt  = 0;
  int   check_cnt = 0;
  logic frame [FL];
  int   m_gap = 0;
  int   m_pos = -1;
  vec_t vecs [24];

  beepboop_id_serializer #(.GAP_CYCLES(G)) dut (
    .clock(clock),
    .reset(reset),
    .en(en),
    .id_valid(id_valid),
    .id_bit(id_bit)
  );

  always #5 clock = ~clock;

  // Reference: a flat position in the 72-bit frame, -1 while idle in the gap
  always @(posedge clock or posedge reset)
    if (reset) begin
      m_gap <= 0;
      m_pos <= -1;
    end else if (m_pos >= 0)
      m_pos <= (m_pos == FL - 1) ? -1 : m_pos + 1;
    else if (en) begin
      if (m_gap == G - 1) begin
        m_gap <= 0;
        m_pos <= 0;
      end else
        m_gap <= m_gap + 1;
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_valid", id_valid, 1'b0);
    check("reset_bit", id_bit, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!id_valid && n < 400) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic read_frame(input int drop_at, output logic [71:0] fb, output int vcnt);
    fb = '0;
    vcnt = 0;
    while (id_valid && vcnt < 200) begin
      fb = {fb[70:0], id_bit};
      vcnt++;
      if (vcnt == drop_at) en = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    string       id_str;
    logic [7:0]  ch;
    logic [7:0]  b_bits;
    logic [71:0] fb;
    int          n;
    int          vcnt;
    logic        hi;
    id_str = "beepboop";
    for (int c = 0; c < 9; c++) begin
      ch = (c < 8) ? 8'(id_str[c]) : 8'h00;
      for (int b = 0; b < 8; b++) frame[c*8+b] = ch[7-b];
    end
    b_bits = 8'h62;
    for (int i = 0; i < 15; i++) vecs[i] = '{en: 1'b1, vld: 1'b0, dat: 1'b0};
    for (int i = 0; i < 8; i++) vecs[15+i] = '{en: 1'b1, vld: 1'b1, dat: b_bits[7-i]};
    vecs[23] = '{en: 1'b1, vld: 1'b1, dat: 1'b0};

    en = 1'b1;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      en = vecs[i].en;
      @(negedge clock);
      check($sformatf("vec%0d_valid", i), id_valid, vecs[i].vld);
      check($sformatf("vec%0d_bit", i), id_bit, vecs[i].dat);
    end

    en = 1'b1;
    do_reset();
    wait_valid(n);
    check("first_gap", n, 16);
    for (int f = 0; f < 3; f++) begin
      read_frame(-1, fb, vcnt);
      check($sformatf("frame%0d_data", f), fb, EXP_FRAME);
      check($sformatf("frame%0d_len", f), vcnt, FL);
      wait_valid(n);
      check($sformatf("frame%0d_gap", f), n, 16);
    end

    en = 1'b1;
    do_reset();
    n = 0;
    while (!id_valid && n < 400) begin
      n++;
      en = (n >= 11 && n <= 15) ? 1'b0 : 1'b1;
      @(negedge clock);
    end
    check("en_pause_delay", n, 21);
    read_frame(-1, fb, vcnt);
    check("en_pause_frame", fb, EXP_FRAME);

    en = 1'b1;
    do_reset();
    wait_valid(n);
    read_frame(28, fb, vcnt);
    check("drop_frame_data", fb, EXP_FRAME);
    check("drop_frame_len", vcnt, FL);
    hi = 1'b0;
    repeat (120) begin
      hi |= id_valid;
      @(negedge clock);
    end
    check("no_frame_while_en_low", hi, 1'b0);
    en = 1'b1;
    wait_valid(n);
    check("resume_gap", n, 16);

    en = 1'b1;
    do_reset();
    wait_valid(n);
    repeat (42) @(negedge clock);
    check("c5_bit_before_reset", {id_valid, id_bit}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", id_valid, 1'b0);
    check("async_reset_bit", id_bit, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_valid(n);
    check("post_reset_gap", n, 16);
    read_frame(-1, fb, vcnt);
    check("post_reset_frame", fb, EXP_FRAME);
    check("post_reset_len", vcnt, FL);

    en = 1'b1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      check("model_valid", id_valid, m_pos >= 0);
      check("model_bit", id_bit, (m_pos >= 0) ? frame[m_pos] : 1'b0);
      reset = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 3) != 0);
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
